fifo_bank4: RTL and testbench

- Bank of four independent circular FIFOs that sits directly upstream of the round-robin arbiter.
- Supplies the per-queue `empty[3:0]` vector the arbiter polls.
- Consumes the arbiter's `pop_id` / `read` pair and delivers the popped word one cycle later on `data_out`.
- Writes arrive from the ingress side tagged with a destination queue id.

---
 rtl/fifo_bank4.sv | 129 ++++++++++++
 tb/tb_fifo_bank4.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_bank4.sv
// Bank of four independent circular FIFOs feeding the round-robin arbiter; pops return data one cycle later.
// Optional same-cycle empty-queue forwarding is compiled in with `define FIFO_BANK_BYPASS_EN.
module fifo_bank4 #(
    parameter int DATA_W   = 10,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int AFULL_TH = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [1:0]        push_id,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read,
    input  logic [1:0]        pop_id,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [3:0]        empty,
    output logic [3:0]        full,
    output logic [3:0]        almost_full,
    output logic              err_overflow,
    output logic              err_underflow
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_TH);

    logic [ADDR_W-1:0] wr_ptr [4];
    logic [ADDR_W-1:0] rd_ptr [4];
    logic [CW-1:0]     count  [4];
    logic [DATA_W-1:0] mem    [4*DEPTH];

    logic              same_q_p0;
    logic              push_ok_p0;
    logic              pop_ok_p0;
    logic              byp_p0;
    logic              ovf_p0;
    logic              unf_p0;
    logic [3:0]        inc_p0;
    logic [3:0]        dec_p0;
    logic [DATA_W-1:0] rdata_p0;

    logic [DATA_W-1:0] dout_p1;
    logic              vld_p1;
    logic              ovf_p1;
    logic              unf_p1;

    // Flags decode straight from the registered counts, so they carry no extra lag.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            empty[i]       = (count[i] == '0);
            full[i]        = (count[i] == FULL_CNT);
            almost_full[i] = (count[i] >= AF_CNT);
        end
    end

    // Stage p0: request qualification against the current occupancy.
    always_comb begin
        same_q_p0 = (push_id == pop_id);
`ifdef FIFO_BANK_BYPASS_EN
        byp_p0    = push && read && same_q_p0 && empty[pop_id];
`else
        byp_p0    = 1'b0;
`endif
        pop_ok_p0  = read && !empty[pop_id];
        // A pop from a full queue frees the slot the same-cycle push lands in.
        push_ok_p0 = push && !byp_p0 && (!full[push_id] || (pop_ok_p0 && same_q_p0));
        ovf_p0     = push && !byp_p0 && !push_ok_p0;
        unf_p0     = read && empty[pop_id] && !byp_p0;

        inc_p0 = 4'b0000;
        dec_p0 = 4'b0000;
        if (push_ok_p0) inc_p0[push_id] = 1'b1;
        if (pop_ok_p0)  dec_p0[pop_id]  = 1'b1;

        rdata_p0 = mem[{pop_id, rd_ptr[pop_id]}];
    end

    // Storage is never reset; a full-queue push overwrites the slot being popped, which reads the old word.
    always_ff @(posedge clk) begin
        if (push_ok_p0)
            mem[{push_id, wr_ptr[push_id]}] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (inc_p0[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (dec_p0[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                case ({inc_p0[i], dec_p0[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Stage p1: registered pop result and error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
            ovf_p1  <= 1'b0;
            unf_p1  <= 1'b0;
        end else begin
            vld_p1 <= pop_ok_p0 || byp_p0;
            ovf_p1 <= ovf_p0;
            unf_p1 <= unf_p0;
            if (pop_ok_p0)
                dout_p1 <= rdata_p0;
            else if (byp_p0)
                dout_p1 <= data_in;
        end
    end

    assign data_out      = dout_p1;
    assign valid_out     = vld_p1;
    assign err_overflow  = ovf_p1;
    assign err_underflow = unf_p1;

endmodule

// File: tb/tb_fifo_bank4.sv
// Directed bench for fifo_bank4: expected pop words go into a queue that a negedge monitor drains and compares.
module tb_fifo_bank4;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic [1:0] push_id;
    logic [9:0] data_in;
    logic       read;
    logic [1:0] pop_id;
    logic [9:0] data_out;
    logic       valid_out;
    logic [3:0] empty;
    logic [3:0] full;
    logic [3:0] almost_full;
    logic       err_overflow;
    logic       err_underflow;

    int         vectors = 0;
    int         miscompares = 0;
    logic [9:0] exp_q [$];
    logic [9:0] exp_d;

    fifo_bank4 dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .push_id       (push_id),
        .data_in       (data_in),
        .read          (read),
        .pop_id        (pop_id),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .empty         (empty),
        .full          (full),
        .almost_full   (almost_full),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic op(input logic p, input logic [1:0] pid, input logic [9:0] d,
                      input logic r, input logic [1:0] rid);
        push    = p;
        push_id = pid;
        data_in = d;
        read    = r;
        pop_id  = rid;
        @(posedge clk);
        #1;
        push = 1'b0;
        read = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && valid_out) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pop: got %0h, expected no valid_out", data_out);
            end else begin
                exp_d = exp_q.pop_front();
                chk("pop_data", 32'(data_out), 32'(exp_d));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        push = 1'b0; push_id = 2'd0; data_in = 10'd0;
        read = 1'b0; pop_id = 2'd0; reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_empty", 32'(empty), 'hF);
        chk("rst_full", 32'(full), 'h0);
        chk("rst_afull", 32'(almost_full), 'h0);
        chk("rst_valid", 32'(valid_out), 'h0);
        chk("rst_data", 32'(data_out), 'h0);
        chk("rst_ovf", 32'(err_overflow), 'h0);
        chk("rst_unf", 32'(err_underflow), 'h0);
        #10 reset = 1'b0;

        // basic two-word push/pop on queue 2
        op(1'b1, 2'd2, 10'h155, 1'b0, 2'd0);
        op(1'b1, 2'd2, 10'h0AA, 1'b0, 2'd0);
        chk("t1_empty_loaded", 32'(empty), 'hB);
        exp_q.push_back(10'h155);
        op(1'b0, 2'd0, 10'd0, 1'b1, 2'd2);
        exp_q.push_back(10'h0AA);
        op(1'b0, 2'd0, 10'd0, 1'b1, 2'd2);
        chk("t1_empty_drained", 32'(empty), 'hF);
        op(1'b0, 2'd0, 10'd0, 1'b0, 2'd0);
        chk("t1_idle_valid", 32'(valid_out), 'h0);
        chk("t1_idle_hold", 32'(data_out), 'h0AA);

        // fill queue 0, overflow, drain in order
        for (int k = 1; k <= 8; k++) begin
            op(1'b1, 2'd0, 10'(k), 1'b0, 2'd0);
            if (k == 5) chk("t2_afull_at5", 32'(almost_full), 'h0);
            if (k == 6) chk("t2_afull_at6", 32'(almost_full), 'h1);
        end
        chk("t2_full", 32'(full), 'h1);
        op(1'b1, 2'd0, 10'd9, 1'b0, 2'd0);
        chk("t2_ovf_pulse", 32'(err_overflow), 'h1);
        chk("t2_full_after_drop", 32'(full), 'h1);
        op(1'b0, 2'd0, 10'd0, 1'b0, 2'd0);
        chk("t2_ovf_cleared", 32'(err_overflow), 'h0);
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back(10'(k));
            op(1'b0, 2'd0, 10'd0, 1'b1, 2'd0);
        end
        chk("t2_empty_drained", 32'(empty), 'hF);

        // underflow on empty queue 3
        op(1'b0, 2'd0, 10'd0, 1'b1, 2'd3);
        chk("t3_unf_pulse", 32'(err_underflow), 'h1);
        chk("t3_valid", 32'(valid_out), 'h0);
        chk("t3_data_hold", 32'(data_out), 'h8);
        op(1'b0, 2'd0, 10'd0, 1'b0, 2'd0);
        chk("t3_unf_cleared", 32'(err_underflow), 'h0);

        // push+pop on a full queue 1
        for (int k = 0; k < 8; k++)
            op(1'b1, 2'd1, 10'(10'h100 + k), 1'b0, 2'd0);
        chk("t4_full", 32'(full), 'h2);
        exp_q.push_back(10'h100);
        op(1'b1, 2'd1, 10'h1FF, 1'b1, 2'd1);
        chk("t4_no_ovf", 32'(err_overflow), 'h0);
        chk("t4_still_full", 32'(full), 'h2);
        chk("t4_no_unf", 32'(err_underflow), 'h0);
        for (int k = 1; k < 8; k++) begin
            exp_q.push_back(10'(10'h100 + k));
            op(1'b0, 2'd0, 10'd0, 1'b1, 2'd1);
        end
        exp_q.push_back(10'h1FF);
        op(1'b0, 2'd0, 10'd0, 1'b1, 2'd1);
        chk("t4_empty_drained", 32'(empty), 'hF);

        // push+pop on empty queue 0
`ifdef FIFO_BANK_BYPASS_EN
        exp_q.push_back(10'h3FF);
        op(1'b1, 2'd0, 10'h3FF, 1'b1, 2'd0);
        chk("t5_byp_unf", 32'(err_underflow), 'h0);
        chk("t5_byp_valid", 32'(valid_out), 'h1);
        chk("t5_byp_empty", 32'(empty), 'hF);
`else
        op(1'b1, 2'd0, 10'h3FF, 1'b1, 2'd0);
        chk("t5_unf", 32'(err_underflow), 'h1);
        chk("t5_valid", 32'(valid_out), 'h0);
        chk("t5_empty", 32'(empty), 'hE);
        exp_q.push_back(10'h3FF);
        op(1'b0, 2'd0, 10'd0, 1'b1, 2'd0);
        chk("t5_empty_drained", 32'(empty), 'hF);
`endif

        // asynchronous reset mid-stream
        op(1'b1, 2'd3, 10'h011, 1'b0, 2'd0);
        op(1'b1, 2'd3, 10'h022, 1'b0, 2'd0);
        op(1'b1, 2'd3, 10'h033, 1'b0, 2'd0);
        exp_q.push_back(10'h011);
        op(1'b0, 2'd0, 10'd0, 1'b1, 2'd3);
        chk("t6_pre_valid", 32'(valid_out), 'h1);
        chk("t6_pre_empty", 32'(empty), 'h7);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_data", 32'(data_out), 'h0);
        chk("t6_rst_valid", 32'(valid_out), 'h0);
        chk("t6_rst_empty", 32'(empty), 'hF);
        chk("t6_rst_full", 32'(full), 'h0);
        chk("t6_rst_afull", 32'(almost_full), 'h0);
        chk("t6_rst_ovf", 32'(err_overflow), 'h0);
        chk("t6_rst_unf", 32'(err_underflow), 'h0);
        #1 reset = 1'b0;

        // normal operation resumes
        op(1'b1, 2'd1, 10'h2AB, 1'b0, 2'd0);
        chk("t7_empty", 32'(empty), 'hD);
        exp_q.push_back(10'h2AB);
        op(1'b0, 2'd0, 10'd0, 1'b1, 2'd1);
        op(1'b0, 2'd0, 10'd0, 1'b0, 2'd0);
        op(1'b0, 2'd0, 10'd0, 1'b0, 2'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
